// File: rtl/dec_gpr_wb_ctl.sv
// ============================================================================
// Module   : dec_gpr_wb_ctl
// Brief    : Two-producer writeback FIFO driving both GPR write ports, with
//            in-order GPR bank switch sequencing and a pending-write vector.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dec_gpr_wb_ctl #(
    parameter int XLEN           = 32,
    parameter int DEPTH          = 4,
    parameter int GPR_BANKS      = 2,
    parameter int GPR_BANKS_LOG2 = 1
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      p0_valid,
    input  logic [4:0]                p0_addr,
    input  logic [XLEN-1:0]           p0_data,
    output logic                      p0_ready,

    input  logic                      p1_valid,
    input  logic [4:0]                p1_addr,
    input  logic [XLEN-1:0]           p1_data,
    output logic                      p1_ready,

    input  logic                      bank_req,
    input  logic [GPR_BANKS_LOG2-1:0] bank_req_id,
    output logic                      bank_req_ready,

    output logic                      wen0,
    output logic [4:0]                waddr0,
    output logic [XLEN-1:0]           wd0,
    output logic                      wen1,
    output logic [4:0]                waddr1,
    output logic [XLEN-1:0]           wd1,

    output logic                      wen_bank_id,
    output logic [GPR_BANKS_LOG2-1:0] wr_bank_id,
    output logic [GPR_BANKS_LOG2-1:0] cur_bank,

    output logic [30:0]               pend_vec,
    output logic                      busy
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_ENQ_LIMIT = c_CNT_W'(DEPTH - 2);
    localparam logic [c_CNT_W-1:0] c_CNT_ZERO  = '0;
    localparam logic [c_CNT_W-1:0] c_CNT_TWO   = c_CNT_W'(2);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DRAIN  = 2'd1,
        S_SWITCH = 2'd2
    } state_t;

    state_t                    r_state;
    logic [c_PTR_W-1:0]        r_head;
    logic [c_PTR_W-1:0]        r_tail;
    logic [c_CNT_W-1:0]        r_count;
    logic [4:0]                r_addr [DEPTH];
    logic [XLEN-1:0]           r_data [DEPTH];
    logic [GPR_BANKS_LOG2-1:0] r_bank_id;
    logic [GPR_BANKS_LOG2-1:0] r_cur_bank;
    logic                      r_wen_bank_id;
    logic [GPR_BANKS_LOG2-1:0] r_wr_bank_id;

    logic                      w_run;
    logic                      w_room;
    logic                      w_acc0;
    logic                      w_acc1;
    logic                      w_enq0;
    logic                      w_enq1;
    logic [c_PTR_W-1:0]        w_head1;
    logic [c_PTR_W-1:0]        w_tail1;
    logic                      w_wen0;
    logic                      w_wen1;
    logic [c_CNT_W-1:0]        w_n_enq;
    logic [c_CNT_W-1:0]        w_n_deq;
    logic [c_PTR_W-1:0]        w_enq_ptr;
    logic [c_PTR_W-1:0]        w_deq_ptr;
    logic [c_CNT_W-1:0]        w_count_nxt;
    logic                      w_req_id_ok;
    logic [DEPTH-1:0]          w_slot_valid;
    logic [30:0]               w_pend;

    // ------------------------------------------------------------------
    // Handshakes: ready depends only on registered state
    // ------------------------------------------------------------------
    assign w_run          = (r_state == S_RUN);
    assign w_room         = (r_count <= c_ENQ_LIMIT);
    assign p0_ready       = w_run & w_room;
    assign p1_ready       = w_run & w_room;
    assign bank_req_ready = w_run;

    assign w_acc0 = p0_valid & p0_ready;
    assign w_acc1 = p1_valid & p1_ready;
    // x0 results are consumed by the handshake but never buffered
    assign w_enq0 = w_acc0 & (p0_addr != 5'd0);
    assign w_enq1 = w_acc1 & (p1_addr != 5'd0);

    // ------------------------------------------------------------------
    // Drain selection
    // ------------------------------------------------------------------
    assign w_head1 = r_head + c_PTR_W'(1);
    assign w_tail1 = r_tail + c_PTR_W'(w_enq0);

    assign w_wen0 = (r_count != c_CNT_ZERO);
    assign w_wen1 = (r_count >= c_CNT_TWO) & (r_addr[w_head1] != r_addr[r_head]);

    assign wen0   = w_wen0;
    assign waddr0 = w_wen0 ? r_addr[r_head]  : 5'd0;
    assign wd0    = w_wen0 ? r_data[r_head]  : '0;
    assign wen1   = w_wen1;
    assign waddr1 = w_wen1 ? r_addr[w_head1] : 5'd0;
    assign wd1    = w_wen1 ? r_data[w_head1] : '0;

    assign w_n_enq     = c_CNT_W'(w_enq0) + c_CNT_W'(w_enq1);
    assign w_n_deq     = c_CNT_W'(w_wen0) + c_CNT_W'(w_wen1);
    assign w_enq_ptr   = c_PTR_W'(w_enq0) + c_PTR_W'(w_enq1);
    assign w_deq_ptr   = c_PTR_W'(w_wen0) + c_PTR_W'(w_wen1);
    assign w_count_nxt = r_count + w_n_enq - w_n_deq;

    // Out-of-range bank ids fall back to the current bank
    assign w_req_id_ok = (32'(bank_req_id) < 32'(GPR_BANKS));

    // ------------------------------------------------------------------
    // Pending-write vector from occupied slots
    // ------------------------------------------------------------------
    always_comb begin
        w_slot_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ({1'b0, c_PTR_W'(i) - r_head} < r_count) begin
                w_slot_valid[i] = 1'b1;
            end
        end
    end

    always_comb begin
        w_pend = '0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 1; j < 32; j++) begin
                if (w_slot_valid[i] && (r_addr[i] == 5'(j))) begin
                    w_pend[j-1] = 1'b1;
                end
            end
        end
    end

    assign pend_vec    = w_pend;
    assign busy        = (r_count != c_CNT_ZERO) | ~w_run;
    assign cur_bank    = r_cur_bank;
    assign wen_bank_id = r_wen_bank_id;
    assign wr_bank_id  = r_wr_bank_id;

    // ------------------------------------------------------------------
    // FIFO payload storage; validity is tracked by head/count
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_enq0) begin
            r_addr[r_tail] <= p0_addr;
            r_data[r_tail] <= p0_data;
        end
        if (w_enq1) begin
            r_addr[w_tail1] <= p1_addr;
            r_data[w_tail1] <= p1_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + w_deq_ptr;
            r_tail  <= r_tail + w_enq_ptr;
            r_count <= w_count_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Bank switch sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_RUN;
            r_bank_id     <= '0;
            r_cur_bank    <= '0;
            r_wen_bank_id <= 1'b0;
            r_wr_bank_id  <= '0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (bank_req) begin
                        r_state   <= S_DRAIN;
                        r_bank_id <= w_req_id_ok ? bank_req_id : r_cur_bank;
                    end
                end
                S_DRAIN: begin
                    // Strobe lands in the cycle right after the last write
                    if (w_count_nxt == c_CNT_ZERO) begin
                        r_state       <= S_SWITCH;
                        r_wen_bank_id <= 1'b1;
                        r_wr_bank_id  <= r_bank_id;
                    end
                end
                S_SWITCH: begin
                    r_state       <= S_RUN;
                    r_cur_bank    <= r_bank_id;
                    r_wen_bank_id <= 1'b0;
                    r_wr_bank_id  <= '0;
                end
                default: begin
                    r_state       <= S_RUN;
                    r_wen_bank_id <= 1'b0;
                    r_wr_bank_id  <= '0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dec_gpr_wb_ctl.sv
// ============================================================================
// Module   : tb_dec_gpr_wb_ctl
// Brief    : Self-checking bench for dec_gpr_wb_ctl against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_dec_gpr_wb_ctl;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int BL    = 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            p0_valid = 1'b0;
    logic [4:0]      p0_addr  = '0;
    logic [XLEN-1:0] p0_data  = '0;
    logic            p0_ready;
    logic            p1_valid = 1'b0;
    logic [4:0]      p1_addr  = '0;
    logic [XLEN-1:0] p1_data  = '0;
    logic            p1_ready;
    logic            bank_req = 1'b0;
    logic [BL-1:0]   bank_req_id = '0;
    logic            bank_req_ready;
    logic            wen0, wen1;
    logic [4:0]      waddr0, waddr1;
    logic [XLEN-1:0] wd0, wd1;
    logic            wen_bank_id;
    logic [BL-1:0]   wr_bank_id;
    logic [BL-1:0]   cur_bank;
    logic [30:0]     pend_vec;
    logic            busy;

    always #5 clk = ~clk;

    dec_gpr_wb_ctl #(.XLEN(XLEN), .DEPTH(DEPTH), .GPR_BANKS(2), .GPR_BANKS_LOG2(BL)) dut (
        .clk(clk), .rst(rst),
        .p0_valid(p0_valid), .p0_addr(p0_addr), .p0_data(p0_data), .p0_ready(p0_ready),
        .p1_valid(p1_valid), .p1_addr(p1_addr), .p1_data(p1_data), .p1_ready(p1_ready),
        .bank_req(bank_req), .bank_req_id(bank_req_id), .bank_req_ready(bank_req_ready),
        .wen0(wen0), .waddr0(waddr0), .wd0(wd0),
        .wen1(wen1), .waddr1(waddr1), .wd1(wd1),
        .wen_bank_id(wen_bank_id), .wr_bank_id(wr_bank_id), .cur_bank(cur_bank),
        .pend_vec(pend_vec), .busy(busy)
    );

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of pending writes plus switch bookkeeping
    typedef struct {
        logic [4:0]      a;
        logic [XLEN-1:0] d;
    } ent_t;

    ent_t            mq[$];
    bit              m_wait   = 1'b0;
    bit              m_strobe = 1'b0;
    logic [BL-1:0]   m_id     = '0;
    logic [BL-1:0]   m_cur    = '0;
    logic [XLEN-1:0] m_gpr [32];
    logic [XLEN-1:0] d_gpr [32];
    int              m_pushes = 0;

    function automatic bit m_ready();
        return !m_wait && !m_strobe && ((DEPTH - mq.size()) >= 2);
    endfunction

    function automatic int m_ndeq();
        if (mq.size() == 0) return 0;
        if (mq.size() >= 2 && mq[1].a != mq[0].a) return 2;
        return 1;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_wait   = 1'b0;
        m_strobe = 1'b0;
        m_id     = '0;
        m_cur    = '0;
    endtask

    task automatic compare_outputs();
        int          nd;
        logic [30:0] ep;
        nd = m_ndeq();
        ep = '0;
        foreach (mq[k]) ep[mq[k].a - 5'd1] = 1'b1;
        chk("wen0",   wen0,   nd >= 1);
        chk("waddr0", waddr0, (nd >= 1) ? mq[0].a : 5'd0);
        chk("wd0",    wd0,    (nd >= 1) ? mq[0].d : '0);
        chk("wen1",   wen1,   nd == 2);
        chk("waddr1", waddr1, (nd == 2) ? mq[1].a : 5'd0);
        chk("wd1",    wd1,    (nd == 2) ? mq[1].d : '0);
        chk("p0_ready", p0_ready, m_ready());
        chk("p1_ready", p1_ready, m_ready());
        chk("bank_req_ready", bank_req_ready, !m_wait && !m_strobe);
        chk("wen_bank_id", wen_bank_id, m_strobe);
        chk("wr_bank_id",  wr_bank_id,  m_strobe ? m_id : '0);
        chk("cur_bank",    cur_bank,    m_cur);
        chk("pend_vec",    pend_vec,    ep);
        chk("busy",        busy,        (mq.size() != 0) || m_wait || m_strobe);
        if (wen0) d_gpr[waddr0] = wd0;
        if (wen1) d_gpr[waddr1] = wd1;
    endtask

    task automatic model_advance();
        bit rdy;
        int nd;
        rdy = m_ready();
        nd  = m_ndeq();
        for (int k = 0; k < nd; k++) begin
            m_gpr[mq[0].a] = mq[0].d;
            void'(mq.pop_front());
        end
        if (m_strobe) begin
            m_cur    = m_id;
            m_strobe = 1'b0;
        end else if (m_wait) begin
            if (mq.size() == 0) begin
                m_wait   = 1'b0;
                m_strobe = 1'b1;
            end
        end else if (bank_req) begin
            m_wait = 1'b1;
            m_id   = bank_req_id;
        end
        if (rdy && p0_valid && p0_addr != 5'd0) begin
            mq.push_back('{a: p0_addr, d: p0_data});
            m_pushes++;
        end
        if (rdy && p1_valid && p1_addr != 5'd0) begin
            mq.push_back('{a: p1_addr, d: p1_data});
            m_pushes++;
        end
    endtask

    // Inputs only change just after posedge, so at negedge they are the
    // values the DUT will sample on the coming edge.
    initial begin : cmp
        forever begin
            @(negedge clk);
            if (rst) begin
                model_reset();
            end else begin
                compare_outputs();
                model_advance();
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        p0_valid = 1'b0; p1_valid = 1'b0; bank_req = 1'b0;
    endtask

    initial begin : stim
        int pulses, pulse_at, last_w, pushes0;
        for (int i = 0; i < 32; i++) begin
            m_gpr[i] = '0;
            d_gpr[i] = '0;
        end

        repeat (3) @(posedge clk);
        #1;
        chk("rst_wen0", wen0, 0);
        chk("rst_pend", pend_vec, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cur_bank", cur_bank, 0);
        rst = 1'b0;
        tick();

        // Single write to x5
        p0_valid = 1'b1; p0_addr = 5'd5; p0_data = 32'hA5A5A5A5;
        #1 chk("t1_p0_ready", p0_ready, 1);
        tick();
        idle_inputs();
        #1;
        chk("t1_wen0", wen0, 1);
        chk("t1_waddr0", waddr0, 5);
        chk("t1_wd0", wd0, 32'hA5A5A5A5);
        chk("t1_pend4", pend_vec[4], 1);
        tick();
        #1 chk("t1_busy", busy, 0);

        // Same-target pair serialises
        p0_valid = 1'b1; p0_addr = 5'd3; p0_data = 32'd1;
        p1_valid = 1'b1; p1_addr = 5'd3; p1_data = 32'd2;
        tick();
        idle_inputs();
        #1;
        chk("t2_wd0_a", wd0, 1);
        chk("t2_wen1", wen1, 0);
        tick();
        #1;
        chk("t2_wd0_b", wd0, 2);
        chk("t2_waddr0", waddr0, 3);
        tick();
        #1 chk("t2_x3_last", d_gpr[3], 2);

        // x0 write is accepted and dropped
        p0_valid = 1'b1; p0_addr = 5'd0; p0_data = 32'hFF;
        #1 chk("t3_ready", p0_ready, 1);
        tick();
        idle_inputs();
        #1;
        chk("t3_wen0", wen0, 0);
        chk("t3_pend", pend_vec, 0);
        chk("t3_busy", busy, 0);

        // Fill to three with stalled producers
        p0_valid = 1'b1; p0_addr = 5'd7; p0_data = 32'd10;
        p1_valid = 1'b1; p1_addr = 5'd7; p1_data = 32'd11;
        tick();
        p0_data = 32'd12; p1_data = 32'd13;
        #1 chk("t4_ready_cnt2", p0_ready, 1);
        tick();
        #1;
        chk("t4_p0_stall", p0_ready, 0);
        chk("t4_p1_stall", p1_ready, 0);
        tick();
        #1 chk("t4_ready_back", p1_ready, 1);
        idle_inputs();
        for (int i = 0; i < 20 && busy; i++) tick();
        chk("t4_drained", busy, 0);

        // Bank switch with three entries queued
        p0_valid = 1'b1; p0_addr = 5'd7; p0_data = 32'd20;
        p1_valid = 1'b1; p1_addr = 5'd7; p1_data = 32'd21;
        tick();
        p0_data = 32'd22; p1_data = 32'd23;
        tick();
        idle_inputs();
        bank_req = 1'b1; bank_req_id = 1'b1;
        #1 chk("t5_breq_ready", bank_req_ready, 1);
        tick();
        bank_req = 1'b0;
        pulses = 0; pulse_at = -1; last_w = -1;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (i == 0) chk("t5_ready_drain", bank_req_ready, 0);
            if (wen0) last_w = i;
            if (pulses == 1 && i == pulse_at + 1) begin
                chk("t5_cur_bank", cur_bank, 1);
                chk("t5_back_run", bank_req_ready, 1);
            end
            if (wen_bank_id) begin
                pulses++;
                pulse_at = i;
                chk("t5_wr_bank_id", wr_bank_id, 1);
            end
            tick();
        end
        chk("t5_pulses", pulses, 1);
        chk("t5_pulse_pos", pulse_at, 2);
        chk("t5_after_last", pulse_at, last_w + 1);

        // Reset while draining two entries
        p0_valid = 1'b1; p0_addr = 5'd9; p0_data = 32'd30;
        p1_valid = 1'b1; p1_addr = 5'd9; p1_data = 32'd31;
        bank_req = 1'b1; bank_req_id = 1'b0;
        tick();
        idle_inputs();
        #1 chk("t6_busy_pre", busy, 1);
        rst = 1'b1;
        #1;
        chk("t6_wen0", wen0, 0);
        chk("t6_pend", pend_vec, 0);
        chk("t6_busy", busy, 0);
        chk("t6_cur_bank", cur_bank, 0);
        chk("t6_wen_bank", wen_bank_id, 0);
        tick();
        tick();
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (wen_bank_id) pulses++;
        end
        chk("t6_no_pulse", pulses, 0);

        // Minimum switch latency from an empty FIFO
        bank_req = 1'b1; bank_req_id = 1'b1;
        tick();
        bank_req = 1'b0;
        #1 chk("t7_no_strobe_yet", wen_bank_id, 0);
        tick();
        #1;
        chk("t7_strobe", wen_bank_id, 1);
        chk("t7_strobe_id", wr_bank_id, 1);
        tick();
        #1 chk("t7_cur_bank", cur_bank, 1);

        // Randomised traffic against the model
        pushes0 = m_pushes;
        for (int c = 0; c < 400; c++) begin
            p0_valid    = ($urandom_range(0, 3) != 0);
            p0_addr     = 5'($urandom_range(0, 7));
            p0_data     = $urandom;
            p1_valid    = ($urandom_range(0, 3) != 0);
            p1_addr     = 5'($urandom_range(0, 7));
            p1_data     = $urandom;
            bank_req    = ($urandom_range(0, 19) == 0);
            bank_req_id = BL'($urandom_range(0, 1));
            tick();
        end
        idle_inputs();
        for (int i = 0; i < 40 && busy; i++) tick();
        chk("rand_drained", busy, 0);
        chk("rand_enough_writes", (m_pushes - pushes0) >= 50, 1);
        tick();
        for (int r = 1; r < 32; r++) chk("gpr_final", d_gpr[r], m_gpr[r]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/dec_gpr_wb_ctl.md
Name: dec_gpr_wb_ctl

Overview:
Writeback initiator for the banked GPR file. It accepts results from two producers (p0 is older, p1 is younger) using valid/ready handshakes and buffers them in an in-order FIFO. Each cycle it drains up to two entries onto the GPR file write ports 0 and 1. It also sequences GPR bank switches, so a switch takes effect only after every older write has been retired, and it publishes a pending-write vector to the decode stall logic.

Parameters:
XLEN, 32, data width of each GPR.
DEPTH, 4, number of FIFO entries; power of 2, minimum 2.
GPR_BANKS, 2, number of GPR banks.
GPR_BANKS_LOG2, 1, width of the bank id.

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
p0_valid  in  1  producer 0 result valid
p0_addr  in  5  producer 0 destination GPR
p0_data  in  XLEN  producer 0 result
p0_ready  out  1  producer 0 accepted
p1_valid  in  1  producer 1 result valid (younger than p0)
p1_addr  in  5  producer 1 destination GPR
p1_data  in  XLEN  producer 1 result
p1_ready  out  1  producer 1 accepted
bank_req  in  1  bank switch request
bank_req_id  in  GPR_BANKS_LOG2  target bank
bank_req_ready  out  1  bank request accepted
wen0, wen1  out  1  GPR write enables
waddr0, waddr1  out  5  GPR write addresses
wd0, wd1  out  XLEN  GPR write data
wen_bank_id  out  1  bank id write strobe
wr_bank_id  out  GPR_BANKS_LOG2  bank id value
cur_bank  out  GPR_BANKS_LOG2  last committed bank
pend_vec  out  31  bit j-1 set when any FIFO entry targets GPR j
busy  out  1  FIFO non-empty or FSM not in RUN

Behaviour:
- Reset (async, rst=1):
  - FIFO empty, count=0, state=RUN, cur_bank=0.
  - All write, bank and pend outputs are 0.
  - Reset mid-drain or mid-switch discards all buffered entries and any pending switch. No write or bank strobe is emitted.
- FSM states: RUN, DRAIN, SWITCH.
  - RUN -> DRAIN on bank_req & bank_req_ready. bank_req_id is latched on that edge.
  - DRAIN -> SWITCH when count==0, after that cycle's drains are counted.
  - SWITCH -> RUN unconditionally after one cycle.
- Handshakes:
  - p0_ready = p1_ready = (state==RUN) & (DEPTH - count >= 2). count is the registered value; same-cycle drains are not credited.
  - A transfer happens when valid & ready. No combinational path from valid to ready.
  - bank_req_ready = (state==RUN).
- Enqueue:
  - Accepted entries are written to the tail in the order p0 then p1.
  - An entry with addr==0 is accepted but not enqueued, since x0 writes are dropped.
  - Enqueues in the same cycle as bank_req acceptance are older than the switch and drain before it.
- Drain:
  - Outputs are combinational from registered FIFO state. An entry enqueued at edge t is visible on wen0 in cycle t+1.
  - wen0 = (count>=1); port 0 carries the head entry.
  - wen1 = (count>=2) & (addr[head+1] != addr[head]); port 1 carries the head+1 entry.
  - If head and head+1 target the same GPR, only the head drains that cycle. This guarantees the two ports never write the same GPR.
  - waddr and wd are zero whenever the matching wen is 0.
  - Pointers wrap modulo DEPTH. count' = count + enq - deq, with 0 <= count <= DEPTH. Simultaneous enqueue and dequeue are allowed.
- SWITCH cycle:
  - wen_bank_id=1 and wr_bank_id=latched id for exactly one cycle.
  - cur_bank is updated to the latched id on the next edge.
  - A request to the current bank still pulses the strobe.
  - A request accepted while count==0 gives minimum latency of 2 cycles to the strobe.
  - No GPR writes occur while in SWITCH.
- pend_vec is the OR of one-hot decodes of all valid entries. It is registered-state derived and excludes same-cycle enqueues.
- busy = (count!=0) | (state!=RUN).

Test Plan:
- Reset, then p0 valid with addr=5, data=0xA5A5A5A5 -> p0_ready=1. Next cycle wen0=1, waddr0=5, wd0=0xA5A5A5A5, pend_vec[4]=1. Following cycle busy=0.
- Same cycle: p0 addr=3 data=1 and p1 addr=3 data=2 -> cycle+1 has wen0 for data 1 with wen1=0. Cycle+2 has wen0 with data 2, so the last value written to x3 is 2.
- p0 addr=0 data=0xFF -> accepted, no wen in any cycle, pend_vec stays 0, count stays 0.
- Fill to count=3 (DEPTH=4) with stalled producers -> p0_ready=p1_ready=0. After one drain cycle both ready return to 1. No entry is lost or reordered; check with a scoreboard of 50 random writes.
- With 3 entries queued, bank_req id=1 -> ready is low during DRAIN. wen_bank_id pulses exactly once after the last GPR write, wr_bank_id=1, cur_bank=1 the next cycle, then the FSM returns to RUN.
- Assert rst during DRAIN with 2 entries queued -> all outputs 0 immediately. After release: count=0, state=RUN, no wen_bank_id pulse, cur_bank=0.
